// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered h/v counters with sync and blank flags.
// Optional frame_tick output is enabled with the VGA_FRAME_TICK_EN macro.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        ce,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic        frame_tick
`endif
);

    localparam int unsigned H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL_I > 2047 || V_TOTAL_I > 2047 || H_TOTAL_I == 0 || V_TOTAL_I == 0) begin : g_param_check
        $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..2047");
    end

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL_I - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL_I - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        h_last;
    logic        v_last;
    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic        hsync_nxt;
    logic        vsync_nxt;
    logic        hblnk_nxt;
    logic        vblnk_nxt;

    // Flags decode the next-state counts so they line up with the registered counts.
    always_comb begin
        h_last    = (hcount == H_LAST);
        v_last    = (vcount == V_LAST);
        h_nxt     = h_last ? 11'd0 : hcount + 11'd1;
        v_nxt     = vcount;
        if (h_last) begin
            v_nxt = v_last ? 11'd0 : vcount + 11'd1;
        end
        hblnk_nxt = (h_nxt >= H_ACT);
        vblnk_nxt = (v_nxt >= V_ACT);
        hsync_nxt = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? H_POL : ~H_POL;
        vsync_nxt = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount <= 11'd0;
            vcount <= 11'd0;
            hblnk  <= 1'b0;
            vblnk  <= 1'b0;
            hsync  <= ~H_POL;
            vsync  <= ~V_POL;
        end else if (ce) begin
            hcount <= h_nxt;
            vcount <= v_nxt;
            hblnk  <= hblnk_nxt;
            vblnk  <= vblnk_nxt;
            hsync  <= hsync_nxt;
            vsync  <= vsync_nxt;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Pulses only on the step into (0,0); cleared on any ce-low cycle.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= ce & h_last & v_last;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry plus a small inverted-polarity geometry,
// both checked every cycle against a position-index reference model.
module tb_vga_timing_gen;

    logic pclk = 1'b0;
    logic rst;
    logic ce;

    logic [10:0] hc_d, vc_d, hc_s, vc_s;
    logic        hs_d, vs_d, hb_d, vb_d;
    logic        hs_s, vs_s, hb_s, vb_s;
`ifdef VGA_FRAME_TICK_EN
    logic        ft_d, ft_s;
`endif

    int          checks = 0;
    int          errors = 0;
    int unsigned p = 0;        // ce-qualified steps since reset release
    bit          last_ce = 1'b0;

    localparam int S_FRAME = 31 * 19;

    always #5 pclk = ~pclk;

    vga_timing_gen dut_d (
        .pclk(pclk), .rst(rst), .ce(ce),
        .hcount(hc_d), .vcount(vc_d), .hsync(hs_d), .vsync(vs_d),
        .hblnk(hb_d), .vblnk(vb_d)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_d)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut_s (
        .pclk(pclk), .rst(rst), .ce(ce),
        .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
        .hblnk(hb_s), .vblnk(vb_s)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_s)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected raster position is just the step index folded by line and frame length.
    task automatic check_geo(input string tag,
                             input logic [10:0] hc, input logic [10:0] vc,
                             input logic hs, input logic vs, input logic hb, input logic vb,
                             input int ha, input int hfp, input int hsw, input int hbp,
                             input int va, input int vfp, input int vsw, input int vbp,
                             input bit hpol, input bit vpol);
        int ht, vt, eh, ev;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        eh = int'(p % ht);
        ev = int'((p / ht) % vt);
        chk({tag, ".hcount"}, 32'(hc), 32'(eh));
        chk({tag, ".vcount"}, 32'(vc), 32'(ev));
        chk({tag, ".hblnk"}, 32'(hb), 32'(eh >= ha));
        chk({tag, ".vblnk"}, 32'(vb), 32'(ev >= va));
        chk({tag, ".hsync"}, 32'(hs), 32'((eh >= ha + hfp && eh < ha + hfp + hsw) ? hpol : !hpol));
        chk({tag, ".vsync"}, 32'(vs), 32'((ev >= va + vfp && ev < va + vfp + vsw) ? vpol : !vpol));
    endtask

    task automatic check_all();
        check_geo("D", hc_d, vc_d, hs_d, vs_d, hb_d, vb_d, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
        check_geo("S", hc_s, vc_s, hs_s, vs_s, hb_s, vb_s, 16, 4, 6, 5, 10, 2, 3, 4, 1'b0, 1'b0);
`ifdef VGA_FRAME_TICK_EN
        chk("D.frame_tick", 32'(ft_d), 32'(last_ce && p != 0 && (p % (1056 * 628)) == 0));
        chk("S.frame_tick", 32'(ft_s), 32'(last_ce && p != 0 && (p % S_FRAME) == 0));
`endif
    endtask

    // Drive ce, let one rising edge happen, update the model, check on the falling edge.
    task automatic cycle(input logic ce_v);
        ce = ce_v;
        @(posedge pclk);
        if (rst && ce_v) p++;
        last_ce = rst && ce_v;
        @(negedge pclk);
        check_all();
    endtask

    initial begin
        int hs_cnt;
        int first_hb;
        int ticks;
        int n;
        bit found;

        rst = 1'b1;
        ce  = 1'b0;
        #2 rst = 1'b0;
        #1 check_all();
        // ce high while in reset must not count
        for (int i = 0; i < 3; i++) cycle(1'b1);
        rst = 1'b1;

        // first line of default geometry
        hs_cnt = 0; first_hb = -1; ticks = 0;
        for (int i = 0; i < 1056; i++) begin
            cycle(1'b1);
            if (hs_d === 1'b1 && vc_d == 11'd0) hs_cnt++;
            if (hb_d === 1'b1 && first_hb < 0) first_hb = int'(hc_d);
`ifdef VGA_FRAME_TICK_EN
            if (ft_s === 1'b1) ticks++;
`endif
        end
        chk("D.line_wrap_h", 32'(hc_d), 32'd0);
        chk("D.line_wrap_v", 32'(vc_d), 32'd1);
        chk("D.hsync_width", 32'(hs_cnt), 32'd128);
        chk("D.first_hblnk", 32'(first_hb), 32'd800);

        // continue through three small frames from release
        while (p < 3 * S_FRAME) begin
            cycle(1'b1);
`ifdef VGA_FRAME_TICK_EN
            if (ft_s === 1'b1) ticks++;
`endif
        end
`ifdef VGA_FRAME_TICK_EN
        chk("S.tick_count_3frames", 32'(ticks), 32'd3);
`endif
        chk("S.frame_wrap_h", 32'(hc_s), 32'd0);
        chk("S.frame_wrap_v", 32'(vc_s), 32'd0);

        // divide-by-2 enable
        for (int i = 0; i < 2 * S_FRAME; i++) cycle(i[0] == 1'b0);

        // random enable pattern
        for (int i = 0; i < 1500; i++) cycle($urandom_range(0, 3) != 0);

        // reset mid-frame inside both sync windows of the small instance
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cycle(1'b1);
            if (hc_s == 11'd22 && vc_s == 11'd13) begin
                found = 1'b1;
                break;
            end
        end
        chk("S.reach_sync_window", 32'(found), 32'd1);
        chk("S.in_hsync_before_rst", 32'(hs_s), 32'd0);
        chk("S.in_vsync_before_rst", 32'(vs_s), 32'd0);
        rst = 1'b0;
        #1;
        p = 0;
        last_ce = 1'b0;
        check_all();
        chk("S.hsync_async_rst", 32'(hs_s), 32'd1);
        chk("S.vsync_async_rst", 32'(vs_s), 32'd1);
        cycle(1'b1);
        cycle(1'b1);
        rst = 1'b1;

        n = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1);
            n++;
            if (vs_s === 1'b0) break;
        end
        chk("S.first_vsync_after_rst", 32'(n), 32'(12 * 31));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
